// File: rtl/seq_alu_pkg.sv
// Shared opcode, flag-index and FSM definitions for the sequential ALU.
package seq_alu_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_ADD = 3'd0;
    localparam logic [OPW-1:0] OP_SUB = 3'd1;
    localparam logic [OPW-1:0] OP_MUL = 3'd2;
    localparam logic [OPW-1:0] OP_DIV = 3'd3;
    localparam logic [OPW-1:0] OP_MOD = 3'd4;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_DIVZERO = 2;
    localparam int FLAG_ILLEGAL = 3;

    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        DONE
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response handshake bundle between the command front-end and the ALU.
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [OPW-1:0]       op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic [3:0]           flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/seq_alu_div.sv
// Iterative restoring divider, one quotient bit per cycle; a zero divisor
// completes immediately with quotient all ones and remainder = dividend.
module seq_alu_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   shifted, trial;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next, quo_next;

    always_comb begin
        shifted   = {rem, quo[WIDTH-1]};
        trial     = shifted - {1'b0, dvs};
        no_borrow = (shifted >= {1'b0, dvs});
        rem_next  = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], no_borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            count <= '0;
        end else if (start) begin
            dvs <= divisor;
            if (divisor == '0) begin
                rem   <= dividend;
                quo   <= '1;
                count <= '0;
            end else begin
                rem   <= '0;
                quo   <= dividend;
                count <= CW'(WIDTH);
            end
        end else if (busy) begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count - CW'(1);
        end
    end

    // done flags the cycle in which the final step is being committed
    assign busy      = (count != '0);
    assign done      = (count == CW'(1));
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/mul, multi-cycle divide/modulo,
// result held until the consumer takes it.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    seq_alu_if.slave bus
);
    localparam int RW = 2 * WIDTH;

    state_t           state, next_state;
    logic             accept, is_divop;
    logic [WIDTH:0]   sum, diff;
    logic [RW-1:0]    alu_res, res_q, div_sel;
    logic [3:0]       alu_flags, flags_q, div_flags;
    logic             sel_div_q, sel_mod_q, dz_q;
    logic             div_busy, div_done;
    logic [WIDTH-1:0] quotient, remainder;

    assign accept   = bus.in_valid && bus.in_ready;
    assign is_divop = (bus.op == OP_DIV) || (bus.op == OP_MOD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (is_divop && bus.b != '0) ? DIV_RUN : DONE;
            DIV_RUN: if (div_done) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_comb begin
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res   = '0;
        alu_flags = '0;
        case (bus.op)
            OP_ADD: begin
                alu_res               = {{(RW-WIDTH-1){1'b0}}, sum};
                alu_flags[FLAG_CARRY] = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res               = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                alu_flags[FLAG_CARRY] = diff[WIDTH];
            end
            OP_MUL:         alu_res = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
            OP_DIV, OP_MOD: alu_res = '0;
            default:        alu_flags[FLAG_ILLEGAL] = 1'b1;
        endcase
        alu_flags[FLAG_ZERO] = (alu_res == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            flags_q   <= '0;
            sel_div_q <= 1'b0;
            sel_mod_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (accept) begin
            res_q     <= alu_res;
            flags_q   <= alu_flags;
            sel_div_q <= (bus.op == OP_DIV);
            sel_mod_q <= (bus.op == OP_MOD);
            dz_q      <= is_divop && (bus.b == '0);
        end
    end

    seq_alu_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_divop),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Divide results live in the divider's own registers, so they are
    // selected rather than copied into res_q.
    always_comb begin
        div_sel                 = {{WIDTH{1'b0}}, sel_mod_q ? remainder : quotient};
        div_flags               = '0;
        div_flags[FLAG_DIVZERO] = dz_q;
        div_flags[FLAG_ZERO]    = (div_sel == '0);
        if (sel_div_q || sel_mod_q) begin
            bus.result = div_sel;
            bus.flags  = div_flags;
        end else begin
            bus.result = res_q;
            bus.flags  = flags_q;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed self-checking bench for seq_alu (WIDTH=8).
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: {flags, result} straight from the arithmetic definition of each opcode
    function automatic logic [19:0] model(input int op, input int a, input int b);
        int r;
        logic [3:0] f;
        f = 4'b0;
        r = 0;
        case (op)
            0: begin r = a + b; f[1] = (r > MASK); end
            1: begin r = (a - b) & MASK; f[1] = (a < b); end
            2: r = a * b;
            3: if (b == 0) begin r = MASK; f[2] = 1'b1; end else r = a / b;
            4: if (b == 0) begin r = a; f[2] = 1'b1; end else r = a % b;
            default: f[3] = 1'b1;
        endcase
        f[0] = (r == 0);
        return {f, r[15:0]};
    endfunction

    function automatic int modelLatency(input int op, input int b);
        return ((op == 3 || op == 4) && b != 0) ? W + 1 : 1;
    endfunction

    // Called at a negedge; returns just after the accepting posedge
    task automatic applyStimulus(input int op, input int a, input int b);
        int n = 0;
        bus.op       = op[2:0];
        bus.a        = a[7:0];
        bus.b        = b[7:0];
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 50);
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic handover(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_ovalid_after"}, int'(bus.out_valid), 0);
        checkOutput({tag, "_iready_after"}, int'(bus.in_ready), 1);
    endtask

    task automatic runOp(input string tag, input int op, input int a, input int b);
        int lat;
        logic [19:0] exp;
        exp = model(op, a, b);
        applyStimulus(op, a, b);
        waitResult(lat);
        checkOutput({tag, "_latency"}, lat, modelLatency(op, b));
        checkOutput({tag, "_result"}, int'(bus.result), int'(exp[15:0]));
        checkOutput({tag, "_flags"}, int'(bus.flags), int'(exp[19:16]));
        handover(tag);
    endtask

    initial begin
        int lat;
        int op, a, b;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_iready", int'(bus.in_ready), 1);
        checkOutput("reset_ovalid", int'(bus.out_valid), 0);
        checkOutput("reset_result", int'(bus.result), 0);
        checkOutput("reset_flags", int'(bus.flags), 0);

        $display("[TB] reset in the middle of a divide");
        applyStimulus(3, 200, 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_ovalid", int'(bus.out_valid), 0);
        checkOutput("abort_iready", int'(bus.in_ready), 1);
        checkOutput("abort_result", int'(bus.result), 0);
        repeat (W + 2) @(negedge clk);
        checkOutput("abort_no_late_result", int'(bus.out_valid), 0);
        runOp("add_1_1", 0, 1, 1);

        $display("[TB] directed operations");
        runOp("add_carry", 0, 200, 100);
        runOp("sub_borrow", 1, 5, 9);
        runOp("mul_max", 2, 255, 255);
        runOp("mul_zero", 2, 0, 77);
        runOp("div_200_7", 3, 200, 7);
        runOp("mod_200_7", 4, 200, 7);
        runOp("mod_6_6", 4, 6, 6);
        runOp("div_by_zero", 3, 13, 0);
        runOp("mod_by_zero", 4, 13, 0);
        runOp("mod_0_by_zero", 4, 0, 0);
        runOp("illegal_6", 6, 0, 0);
        runOp("div_255_1", 3, 255, 1);
        runOp("sub_equal", 1, 42, 42);

        $display("[TB] backpressure");
        applyStimulus(0, 3, 4);
        waitResult(lat);
        checkOutput("bp_latency", lat, 1);
        bus.op       = 3'd1;
        bus.a        = 8'd10;
        bus.b        = 8'd3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checkOutput("bp_result_stable", int'(bus.result), 7);
            checkOutput("bp_iready_low", int'(bus.in_ready), 0);
            checkOutput("bp_ovalid_high", int'(bus.out_valid), 1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_handover_ovalid", int'(bus.out_valid), 0);
        checkOutput("bp_handover_iready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waitResult(lat);
        checkOutput("bp_second_latency", lat, 1);
        checkOutput("bp_second_result", int'(bus.result), 7);
        checkOutput("bp_second_flags", int'(bus.flags), 0);
        handover("bp_second");

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, MASK));
            b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, MASK));
            runOp($sformatf("rand%0d_op%0d_%0d_%0d", i, op, a, b), op, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
